// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message scheduler: sequencer states,
// core-state codes, the last round index and the small-sigma functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    RUN,
    LAST,
    HOLD
  } sched_state_t;

  localparam logic [1:0] CORE_IDLE  = 2'b00;
  localparam logic [1:0] CORE_ROUND = 2'b01;
  localparam logic [1:0] CORE_LAST  = 2'b10;
  localparam logic [1:0] CORE_HOLD  = 2'b11;

  localparam logic [5:0] ROUND_LIMIT = 6'd63;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: W_t from W_{t-2}, W_{t-7}, W_{t-15}, W_{t-16}.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_new
);

  assign w_new = ssig1(w_m2) + w_m7 + ssig0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_sched.sv
// Buffers one 512-bit block over valid/ready, then sequences the compression
// core through rounds 0..63 while supplying W_t from a 16-word circular buffer.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  start_out,
  output logic [1:0]            fsm_state_out,
  output logic [5:0]            round_out,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  busy_out
);

  // Handshake: a word transfers on a rising edge where valid_in and ready_out
  // are both high; ready_out depends only on state, never on valid_in.
  sched_state_t state;
  logic [3:0]   count;
  logic [5:0]   round;
  logic [31:0]  wbuf [16];
  logic [31:0]  w_new;
  logic         accept;
  logic         in_rounds;
  logic [3:0]   i_m2;
  logic [3:0]   i_m7;
  logic [3:0]   i_m15;
  logic [3:0]   i_cur;

  assign accept    = valid_in & ready_out;
  assign in_rounds = (state == RUN) || (state == LAST);

  // 4-bit index arithmetic gives the mod-16 wrap of the circular buffer.
  assign i_cur = round[3:0];
  assign i_m2  = round[3:0] + 4'd14;
  assign i_m7  = round[3:0] + 4'd9;
  assign i_m15 = round[3:0] + 4'd1;

  sha256_w_expand u_expand (
    .w_m2  (wbuf[i_m2]),
    .w_m7  (wbuf[i_m7]),
    .w_m15 (wbuf[i_m15]),
    .w_m16 (wbuf[i_cur]),
    .w_new (w_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
      round <= 6'd0;
      for (int i = 0; i < 16; i++) wbuf[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wbuf[0] <= data_in;
            count   <= 4'd1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            wbuf[count] <= data_in;
            count       <= count + 4'd1;
            if (count == 4'd15) state <= INIT;
          end
        end
        INIT: begin
          round <= 6'd0;
          state <= RUN;
        end
        RUN: begin
          if (round >= 6'd16) wbuf[i_cur] <= w_new;
          round <= round + 6'd1;
          if (round == ROUND_LIMIT - 6'd1) state <= LAST;
        end
        LAST: begin
          wbuf[i_cur] <= w_new;
          round       <= 6'd0;
          state       <= HOLD;
        end
        HOLD: begin
          count <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    fsm_state_out = CORE_IDLE;
    case (state)
      RUN:     fsm_state_out = CORE_ROUND;
      LAST:    fsm_state_out = CORE_LAST;
      HOLD:    fsm_state_out = CORE_HOLD;
      default: fsm_state_out = CORE_IDLE;
    endcase
  end

  assign ready_out = (state == IDLE) || (state == LOAD);
  assign busy_out  = ~ready_out;
  assign start_out = (state == INIT);
  assign round_out = round;

  // Rounds 0..15 read the buffered message; later rounds use the expansion.
  assign w_out = !in_rounds     ? '0 :
                 (round < 6'd16) ? wbuf[i_cur] : w_new;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: table of known blocks, random back-to-back
// blocks against a reference schedule, and a full SHA-256 digest of "abc".
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        start_out;
  logic [1:0]  fsm_state_out;
  logic [5:0]  round_out;
  logic [31:0] w_out;
  logic        busy_out;

  always #5 clk = ~clk;

  sha256_msg_sched #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .start_out     (start_out),
    .fsm_state_out (fsm_state_out),
    .round_out     (round_out),
    .w_out         (w_out),
    .busy_out      (busy_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cur_msg [16];
  logic [31:0] blocks  [4][16];
  logic [31:0] next_w0;
  int          widx;
  logic [31:0] exp_q [$];
  logic [31:0] obs_w16, obs_w17;
  logic [31:0] hs [8];

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] h_init [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  logic [31:0] abc_digest [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w15;
    logic [31:0] exp_w16;
    logic [31:0] exp_w17;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference schedule straight from the message-expansion recurrence.
  task automatic build_expected();
    logic [31:0] w [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = cur_msg[t];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    exp_q.delete();
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  task automatic comp_round(input int t, input logic [31:0] w);
    logic [31:0] t1, t2, s0v, s1v, ch, maj;
    s1v = rotr(hs[4], 6) ^ rotr(hs[4], 11) ^ rotr(hs[4], 25);
    ch  = (hs[4] & hs[5]) ^ (~hs[4] & hs[6]);
    t1  = hs[7] + s1v + ch + k_tab[t] + w;
    s0v = rotr(hs[0], 2) ^ rotr(hs[0], 13) ^ rotr(hs[0], 22);
    maj = (hs[0] & hs[1]) ^ (hs[0] & hs[2]) ^ (hs[1] & hs[2]);
    t2  = s0v + maj;
    hs[7] = hs[6]; hs[6] = hs[5]; hs[5] = hs[4]; hs[4] = hs[3] + t1;
    hs[3] = hs[2]; hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = t1 + t2;
  endtask

  task automatic drive_load(input bit gaps);
    valid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    data_in  = valid_in ? cur_msg[widx] : $urandom();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_out), 32'd1);
    chk({tag, "_start"}, 32'(start_out), 32'd0);
    chk({tag, "_fsm"},   32'(fsm_state_out), 32'd0);
    chk({tag, "_round"}, 32'(round_out), 32'd0);
    chk({tag, "_w"},     w_out, 32'd0);
    chk({tag, "_busy"},  32'(busy_out), 32'd0);
  endtask

  // Caller has already driven the inputs for the current cycle.
  task automatic run_block(input bit gaps, input bit hold_valid, input bit do_digest);
    int cyc;
    logic [31:0] exp_w;
    int exp_fsm, exp_round;
    build_expected();
    widx = 0;
    cyc  = 0;
    while (widx < 16 && cyc < 400) begin
      @(negedge clk);
      chk("load_ready", 32'(ready_out), 32'd1);
      chk("load_busy",  32'(busy_out), 32'd0);
      chk("load_fsm",   32'(fsm_state_out), 32'd0);
      chk("load_start", 32'(start_out), 32'd0);
      if (valid_in) widx++;
      cyc++;
      @(posedge clk); #1;
      if (widx < 16) drive_load(gaps);
      else begin
        valid_in = hold_valid;
        data_in  = hold_valid ? next_w0 : $urandom();
      end
    end
    if (widx < 16) begin
      chk("load_timeout", 32'(widx), 32'd16);
      return;
    end
    if (do_digest) for (int i = 0; i < 8; i++) hs[i] = h_init[i];
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      exp_fsm   = (k == 1) ? 0 : (k <= 64) ? 1 : (k == 65) ? 2 : 3;
      exp_round = (k >= 2 && k <= 65) ? k - 2 : 0;
      exp_w     = (k >= 2 && k <= 65) ? exp_q.pop_front() : 32'd0;
      chk("busy_fsm",   32'(fsm_state_out), 32'(exp_fsm));
      chk("busy_round", 32'(round_out), 32'(exp_round));
      chk("busy_w",     w_out, exp_w);
      chk("busy_start", 32'(start_out), 32'(k == 1));
      chk("busy_busy",  32'(busy_out), 32'd1);
      chk("busy_ready", 32'(ready_out), 32'd0);
      if (k == 18) obs_w16 = w_out;
      if (k == 19) obs_w17 = w_out;
      if (do_digest && k >= 2 && k <= 65) comp_round(k - 2, w_out);
      if (do_digest && k == 65)
        for (int i = 0; i < 8; i++) chk("digest", hs[i] + h_init[i], abc_digest[i]);
      @(posedge clk); #1;
      valid_in = hold_valid;
      data_in  = hold_valid ? next_w0 : $urandom();
    end
  endtask

  initial begin
    vecs[0] = '{w0: 32'h61626380, w15: 32'h00000018, exp_w16: 32'h61626380, exp_w17: 32'h000F0000};
    vecs[1] = '{w0: 32'hdeadbeef, w15: 32'h00000000, exp_w16: 32'hdeadbeef, exp_w17: 32'h00000000};
    vecs[2] = '{w0: 32'h00000000, w15: 32'h00000001, exp_w16: 32'h00000000, exp_w17: 32'h0000A000};
    vecs[3] = '{w0: 32'h12345678, w15: 32'h80000000, exp_w16: 32'h12345678, exp_w17: 32'h00205000};

    // Clock/reset
    rst = 1'b1; valid_in = 1'b0; data_in = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset after five words of an abandoned block
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = $urandom();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    valid_in = 1'b1;
    data_in = $urandom();
    @(negedge clk);
    check_reset_outputs("midload");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midload_hold");
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of known blocks; entry 0 is "abc" and also checks the digest
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) cur_msg[i] = 32'd0;
      cur_msg[0]  = vecs[v].w0;
      cur_msg[15] = vecs[v].w15;
      widx = 0;
      drive_load(v[0]);
      run_block(v[0], 1'b0, v == 0);
      chk("tab_w16", obs_w16, vecs[v].exp_w16);
      chk("tab_w17", obs_w17, vecs[v].exp_w17);
    end

    // Random blocks back to back, valid held high through busy
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++) blocks[b][i] = $urandom();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) cur_msg[i] = blocks[b][i];
      next_w0 = (b < 3) ? blocks[b+1][0] : 32'd0;
      if (b == 0) begin
        widx = 0;
        drive_load(1'b1);
      end
      run_block(1'b1, b < 3, 1'b0);
    end

    @(negedge clk);
    check_reset_outputs("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Message scheduler and sequencer that feeds the SHA-256 compression core.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready handshake and buffers them.
- Then drives the core's start/state/round controls and supplies W_t for rounds 0..63 in the same cycle as the matching round index.
- Single-block only: the core applies the fixed initial hash H0..H7.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
data_in  input  DATA_WIDTH  message word; the first word accepted is W0
valid_in  input  1  data_in is valid
ready_out  output  1  scheduler accepts a word this cycle
start_out  output  1  one-cycle pulse; the core loads H0..H7
fsm_state_out  output  2  core state: 00 idle/load/init, 01 rounds 0..62, 10 round 63, 11 hold
round_out  output  6  current round t
w_out  output  DATA_WIDTH  W_t for round_out, combinational from registers
busy_out  output  1  high from INIT through HOLD

Behaviour:
- Reset (async, rst=1): state=IDLE; word count 0; round 0; buffer cleared. Outputs: ready_out=1, start_out=0, fsm_state_out=00, round_out=0, w_out=0, busy_out=0. Reset mid-block abandons the block and needs no flush.
- Internal states and outputs:
  - IDLE and LOAD: fsm 00, ready_out=1.
  - INIT: fsm 00, start_out=1.
  - RUN: fsm 01.
  - LAST: fsm 10.
  - HOLD: fsm 11.
  - ready_out=0 in INIT, RUN, LAST and HOLD.
- Accept condition: valid_in & ready_out.
- IDLE: an accept writes buf[0], count=1, next state LOAD.
- LOAD: each accept writes buf[count], count++. The accept at count=15 moves to INIT.
- Timing from the 16th accept at cycle c:
  - INIT at c+1.
  - RUN, round 0, at c+2.
  - Round 62 at c+64.
  - LAST, round 63, at c+65.
  - HOLD at c+66.
  - IDLE at c+67.
- Total 66 cycles from the last accept to the return to IDLE (c+1 through c+66).
- RUN and LAST advance exactly one round per cycle with no stalls. valid_in is ignored while busy.
- Schedule, circular 16-entry buffer indexed by t[3:0]:
  - t<16: w_out = buf[t].
  - t>=16: w_out = s1(buf[t+14]) + buf[t+9] + s0(buf[t+1]) + buf[t], all indices mod 16, sum mod 2^32.
  - For t>=16, w_out is written into buf[t[3:0]] at the clock edge ending round t.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- w_out=0 outside RUN and LAST. round_out=0 outside RUN and LAST.
- round_out wraps only via state exit: at LAST (round 63) it goes to HOLD and resets to 0. The 6-bit counter must never reach 64.
- A word presented with valid_in in HOLD is not accepted. It is accepted in the following IDLE cycle.

Decomposition:
- Package sha256_pkg holds:
  - state encodings IDLE, LOAD, INIT, RUN, LAST, HOLD;
  - core-state constants 2'b00, 2'b01, 2'b10, 2'b11;
  - the round limit 63;
  - s0/s1 functions.
- One sub-module, sha256_w_expand, is combinational: it takes four buffer words and returns the new W.
- Control and the buffer stay in the top module.

Test Plan:
1. Reset-values check: assert rst mid-LOAD after 5 words, release, then send 16 words.
   - The block restarts at W0.
   - All outputs hold their reset values during rst.
2. "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018.
   - At round 16, w_out=0x61626380.
   - At round 17, w_out=0x000F0000.
   - start_out pulses exactly once, one cycle before round 0.
3. Timing: record the cycle c of the last accept.
   - fsm sequence is 00 (c+1), 01 (c+2..c+64), 10 (c+65), 11 (c+66), 00.
   - round_out reads 0..63 with no gaps.
4. Backpressure and gaps: toggle valid_in randomly during LOAD, and hold valid_in=1 through busy.
   - Exactly 16 words are captured, in order.
   - No accept occurs while busy_out=1.
   - The next block starts in the first IDLE cycle.
5. Integration with the compression core, "abc" block: at fsm 10, round 63, out0..out7 equal ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
6. Back-to-back blocks: two different blocks sent consecutively.
   - The second block's W16 is computed from the second block only; no stale buffer words.
